// File: rtl/i2c_expander_sched.sv
// Sequences a byte-level I2C master for a PCA9555-style 16-bit port expander: initialises the
// inversion and DDR register pairs, polls the input pair periodically and serialises host writes.
module i2c_expander_sched #(
  parameter logic [6:0]  DEV_ADDR       = 7'h24,
  parameter logic [15:0] DDR_INIT       = 16'hDFC0,
  parameter logic [15:0] INV_INIT       = 16'h0000,
  parameter int unsigned POLL_CYCLES    = 6000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [1:0]  wr_pair,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [15:0] port_in,
  output logic        port_in_valid,
  output logic        init_done,
  output logic        err,
  output logic        m_reset_n,
  output logic        m_ena,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wdata,
  input  logic        m_busy,
  input  logic [7:0]  m_rdata,
  input  logic        m_ack_error
);

  localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StRst, StInitInv, StInitDdr, StIdle, StWr, StRd} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          poll_pend_q, poll_pend_d;
  logic          busy_last_q, busy_last_d;
  logic [1:0]    b_q, b_d;
  logic [1:0]    nfall_q, nfall_d;
  logic          fail_q, fail_d;
  logic [15:0]   data_q, data_d;
  logic [7:0]    rd_lo_q, rd_lo_d;
  logic          m_ena_q, m_ena_d, m_rw_q, m_rw_d, m_reset_n_q, m_reset_n_d;
  logic [7:0]    m_wdata_q, m_wdata_d;
  logic          wr_ack_q, wr_ack_d, valid_q, valid_d, init_done_q, init_done_d, err_q, err_d;
  logic [15:0]   port_in_q, port_in_d;

  logic        rise, fall, expire, in_txn, is_rd, txn_end, txn_ok, start;
  logic [7:0]  start_ptr;
  logic [15:0] start_data;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    poll_pend_d = poll_pend_q;
    busy_last_d = m_busy;
    b_d         = b_q;
    nfall_d     = nfall_q;
    fail_d      = fail_q;
    data_d      = data_q;
    rd_lo_d     = rd_lo_q;
    m_ena_d     = m_ena_q;
    m_rw_d      = m_rw_q;
    m_wdata_d   = m_wdata_q;
    m_reset_n_d = 1'b1;
    wr_ack_d    = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    port_in_d   = port_in_q;
    start       = 1'b0;
    start_ptr   = 8'h00;
    start_data  = 16'h0000;
    txn_end     = 1'b0;
    txn_ok      = 1'b0;

    rise    = m_busy & ~busy_last_q;
    fall    = ~m_busy & busy_last_q;
    expire  = (timer_q == PW'(POLL_CYCLES - 1));
    timer_d = expire ? '0 : timer_q + 1'b1;
    poll_pend_d = poll_pend_q | expire;

    in_txn = (state_q == StInitInv) || (state_q == StInitDdr) ||
             (state_q == StWr) || (state_q == StRd);
    is_rd  = (state_q == StRd);

    if (in_txn) begin
      tmo_d = tmo_q + 1'b1;
      if (rise) begin
        if (b_q != 2'd3) b_d = b_q + 2'd1;
        case (b_q)
          2'd0: begin
            if (is_rd) m_rw_d = 1'b1;  // repeated start into the read phase
            else m_wdata_d = data_q[7:0];
          end
          2'd1: if (!is_rd) m_wdata_d = data_q[15:8];
          2'd2: m_ena_d = 1'b0;
          default: ;
        endcase
      end
      if (fall) begin
        if (nfall_q != 2'd3) nfall_d = nfall_q + 2'd1;
        if (m_ack_error) fail_d = 1'b1;
        if (is_rd && nfall_q == 2'd1) rd_lo_d = m_rdata;
        if (!m_ena_q) begin
          txn_end = 1'b1;
          txn_ok  = ~(fail_q | m_ack_error);
        end
      end
      if (!txn_end && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        txn_end     = 1'b1;
        m_ena_d     = 1'b0;
        m_reset_n_d = 1'b0;  // kick the master out of whatever it is stuck in
      end
    end

    case (state_q)
      StRst: begin
        start      = 1'b1;
        start_ptr  = 8'h04;
        start_data = INV_INIT;
        state_d    = StInitInv;
      end
      StInitInv: if (txn_end) begin
        if (txn_ok) begin
          start      = 1'b1;
          start_ptr  = 8'h06;
          start_data = DDR_INIT;
          state_d    = StInitDdr;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StInitDdr: if (txn_end) begin
        init_done_d = txn_ok;
        err_d       = ~txn_ok;
        state_d     = StIdle;
      end
      StWr: if (txn_end) begin
        wr_ack_d = 1'b1;
        err_d    = ~txn_ok;
        state_d  = StIdle;
      end
      StRd: if (txn_end) begin
        if (txn_ok) begin
          port_in_d = {m_rdata, rd_lo_q};
          valid_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      StIdle: begin
        if (!init_done_q) begin
          if (poll_pend_q || expire) begin
            poll_pend_d = 1'b0;
            start       = 1'b1;
            start_ptr   = 8'h04;
            start_data  = INV_INIT;
            state_d     = StInitInv;
          end
        end else if (wr_req && !wr_ack_q) begin
          if (wr_pair == 2'd0) begin
            wr_ack_d = 1'b1;
          end else begin
            start      = 1'b1;
            start_ptr  = {5'd0, wr_pair, 1'b0};
            start_data = wr_data;
            state_d    = StWr;
          end
        end else if (poll_pend_q || expire) begin
          poll_pend_d = 1'b0;
          start       = 1'b1;
          start_ptr   = 8'h00;
          state_d     = StRd;
        end
      end
      default: state_d = StRst;
    endcase

    if (start) begin
      m_ena_d   = 1'b1;
      m_rw_d    = 1'b0;
      m_wdata_d = start_ptr;
      data_d    = start_data;
      b_d       = 2'd0;
      nfall_d   = 2'd0;
      fail_d    = 1'b0;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      state_q     <= StRst;
      timer_q     <= '0;
      tmo_q       <= '0;
      poll_pend_q <= 1'b0;
      busy_last_q <= 1'b0;
      b_q         <= 2'd0;
      nfall_q     <= 2'd0;
      fail_q      <= 1'b0;
      data_q      <= 16'h0000;
      rd_lo_q     <= 8'h00;
      m_ena_q     <= 1'b0;
      m_rw_q      <= 1'b0;
      m_wdata_q   <= 8'h00;
      m_reset_n_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      port_in_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      poll_pend_q <= poll_pend_d;
      busy_last_q <= busy_last_d;
      b_q         <= b_d;
      nfall_q     <= nfall_d;
      fail_q      <= fail_d;
      data_q      <= data_d;
      rd_lo_q     <= rd_lo_d;
      m_ena_q     <= m_ena_d;
      m_rw_q      <= m_rw_d;
      m_wdata_q   <= m_wdata_d;
      m_reset_n_q <= m_reset_n_d;
      wr_ack_q    <= wr_ack_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      port_in_q   <= port_in_d;
    end
  end

  assign m_addr        = DEV_ADDR;
  assign m_ena         = m_ena_q;
  assign m_rw          = m_rw_q;
  assign m_wdata       = m_wdata_q;
  assign m_reset_n     = m_reset_n_q;
  assign wr_ack        = wr_ack_q;
  assign port_in_valid = valid_q;
  assign init_done     = init_done_q;
  assign err           = err_q;
  assign port_in       = port_in_q;

endmodule

// File: tb/tb_i2c_expander_sched.sv
// Bench for i2c_expander_sched: a behavioural I2C master answers the bus while directed steps
// exercise init, polling, host writes, NAK, timeout and mid-read reset.
module tb_i2c_expander_sched;

  localparam int unsigned POLL = 400;
  localparam int unsigned TMO  = 150;
  localparam int          BYTE = 10;

  logic        clk48 = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [1:0]  wr_pair;
  logic [15:0] wr_data;
  logic        wr_ack, port_in_valid, init_done, err;
  logic [15:0] port_in;
  logic        m_reset_n, m_ena, m_rw, m_busy, m_ack_error;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata, m_rdata;

  int nchk = 0;
  int nfail = 0;
  int nvalid = 0;
  int nerr = 0;
  int tcnt = 0;
  bit stall = 1'b0;
  bit nak_ddr = 1'b0;

  logic [8:0] exp_q[$];  // expected {rw, wdata} at each byte the master accepts
  logic [7:0] rdq[$];    // data the model returns on read bytes

  i2c_expander_sched #(
    .POLL_CYCLES   (POLL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk48        (clk48),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_pair      (wr_pair),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .port_in      (port_in),
    .port_in_valid(port_in_valid),
    .init_done    (init_done),
    .err          (err),
    .m_reset_n    (m_reset_n),
    .m_ena        (m_ena),
    .m_addr       (m_addr),
    .m_rw         (m_rw),
    .m_wdata      (m_wdata),
    .m_busy       (m_busy),
    .m_rdata      (m_rdata),
    .m_ack_error  (m_ack_error)
  );

  always #5 clk48 = ~clk48;

  // Poll-timer mirror and pulse counters
  always @(posedge clk48) begin
    if (reset) tcnt <= 0;
    else if (tcnt == POLL - 1) tcnt <= 0;
    else tcnt <= tcnt + 1;
    if (port_in_valid) nvalid <= nvalid + 1;
    if (err) nerr <= nerr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input logic [7:0] ptr, input logic [15:0] d);
    exp_q.push_back({1'b0, ptr});
    exp_q.push_back({1'b0, d[7:0]});
    exp_q.push_back({1'b0, d[15:8]});
  endtask

  task automatic push_rd(input logic [7:0] lo, input logic [7:0] hi);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    rdq.push_back(lo);
    rdq.push_back(hi);
  endtask

  // Behavioural byte-level master: one busy rise per accepted command, one fall per finished byte
  int mst = 0, mcnt = 0, bidx = 0;
  bit cur_rd, cur_nak;
  logic [8:0] cmd;

  task automatic do_rise();
    cmd = {m_rw, m_wdata};
    check("bus_pending", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) check("bus_byte", 32'(cmd), 32'(exp_q.pop_front()));
    cur_rd  = m_rw;
    cur_nak = nak_ddr && (bidx == 0) && (cmd == 9'h006);
    if (cur_nak) nak_ddr = 1'b0;
    m_busy = 1'b1;
    mst    = 1;
    mcnt   = 0;
  endtask

  initial begin
    m_busy = 1'b0;
    m_rdata = 8'h00;
    m_ack_error = 1'b0;
    forever begin
      @(posedge clk48);
      #1;
      if (m_reset_n !== 1'b1) begin
        m_busy = 1'b0;
        m_ack_error = 1'b0;
        mst = 0;
        mcnt = 0;
        bidx = 0;
      end else begin
        case (mst)
          0: begin
            if (m_ena && !stall) begin
              mcnt++;
              if (mcnt >= 2) do_rise();
            end else mcnt = 0;
          end
          1: begin
            mcnt++;
            if (mcnt == BYTE) begin
              if (cur_rd) m_rdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
              m_ack_error = cur_nak;
              bidx = m_ena ? bidx + 1 : 0;
              m_busy = 1'b0;
              mst = 2;
              mcnt = 0;
            end
          end
          default: begin
            m_ack_error = 1'b0;
            mcnt++;
            if (mcnt == 2) begin
              if (m_ena) do_rise();
              else begin
                mst = 0;
                mcnt = 0;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic wait_init(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      if (init_done) break;
    end
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      if (port_in_valid) break;
    end
  endtask

  task automatic wait_ack(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      if (wr_ack) break;
    end
  endtask

  int e0, v0;

  initial begin
    reset = 1'b1;
    wr_req = 1'b0;
    wr_pair = 2'd0;
    wr_data = 16'h0000;
    repeat (3) @(negedge clk48);
    check("rst_m_ena", 32'(m_ena), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd0);
    check("rst_m_wdata", 32'(m_wdata), 32'h00);
    check("rst_m_addr", 32'(m_addr), 32'h24);
    check("rst_m_reset_n", 32'(m_reset_n), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_port_in", 32'(port_in), 32'h0000);
    check("rst_valid", 32'(port_in_valid), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Initialisation writes
    push_wr(8'h04, 16'h0000);
    push_wr(8'h06, 16'hDFC0);
    reset = 1'b0;
    @(negedge clk48);
    check("m_reset_n_released", 32'(m_reset_n), 32'd1);
    wait_init(300);
    check("init_done", 32'(init_done), 32'd1);
    @(negedge clk48);
    check("init_err_cnt", 32'(nerr), 32'd0);
    check("init_bus_left", 32'(exp_q.size()), 32'd0);

    // First poll
    push_rd(8'h5A, 8'hA5);
    wait_valid(600);
    check("poll_valid", 32'(port_in_valid), 32'd1);
    check("poll_port_in", 32'(port_in), 32'hA55A);
    @(negedge clk48);
    check("poll_valid_1cyc", 32'(port_in_valid), 32'd0);
    check("poll_valid_cnt", 32'(nvalid), 32'd1);

    // Host write raised in the same cycle as timer expiry
    for (int i = 0; i < 1000; i++) begin
      if (tcnt == POLL - 1) break;
      @(negedge clk48);
    end
    check("expiry_found", 32'(tcnt == POLL - 1), 32'd1);
    wr_req = 1'b1;
    wr_pair = 2'd1;
    wr_data = 16'h0020;
    push_wr(8'h02, 16'h0020);
    push_rd(8'h12, 8'h34);
    @(negedge clk48);
    wr_data = 16'hFFFF;  // must be ignored once the write has started
    wr_pair = 2'd3;
    wait_ack(300);
    check("wr_ack", 32'(wr_ack), 32'd1);
    check("wr_err", 32'(err), 32'd0);
    check("poll_after_wr", 32'(nvalid), 32'd1);
    wr_req = 1'b0;
    wait_valid(300);
    check("pend_poll_port_in", 32'(port_in), 32'h3412);
    repeat (3) @(negedge clk48);
    check("pend_valid_cnt", 32'(nvalid), 32'd2);
    check("wr_bus_left", 32'(exp_q.size()), 32'd0);

    // NAK during INIT_DDR, retry at the next expiry
    e0 = nerr;
    reset = 1'b1;
    repeat (2) @(negedge clk48);
    nak_ddr = 1'b1;
    push_wr(8'h04, 16'h0000);
    push_wr(8'h06, 16'hDFC0);
    reset = 1'b0;
    repeat (200) @(negedge clk48);
    check("nak_init_done", 32'(init_done), 32'd0);
    check("nak_err_cnt", 32'(nerr - e0), 32'd1);
    check("nak_bus_left", 32'(exp_q.size()), 32'd0);
    push_wr(8'h04, 16'h0000);
    push_wr(8'h06, 16'hDFC0);
    wait_init(400);
    check("retry_init_done", 32'(init_done), 32'd1);
    @(negedge clk48);
    check("retry_err_cnt", 32'(nerr - e0), 32'd1);

    // Master stalls during a write: timeout
    stall = 1'b1;
    wr_req = 1'b1;
    wr_pair = 2'd3;
    wr_data = 16'h1234;
    wait_ack(TMO + 50);
    check("tmo_wr_ack", 32'(wr_ack), 32'd1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_m_reset_n", 32'(m_reset_n), 32'd0);
    check("tmo_m_ena", 32'(m_ena), 32'd0);
    wr_req = 1'b0;
    @(negedge clk48);
    check("tmo_m_reset_n_back", 32'(m_reset_n), 32'd1);
    stall = 1'b0;
    push_rd(8'hC3, 8'h3C);
    wait_valid(400);
    check("tmo_then_poll", 32'(port_in), 32'h3CC3);

    // Reset in the middle of a read
    push_rd(8'h77, 8'h88);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk48);
      if (m_rw) break;
    end
    check("rd_started", 32'(m_rw), 32'd1);
    v0 = nvalid;
    reset = 1'b1;
    @(negedge clk48);
    check("rrst_m_ena", 32'(m_ena), 32'd0);
    check("rrst_m_reset_n", 32'(m_reset_n), 32'd0);
    exp_q.delete();
    rdq.delete();
    push_wr(8'h04, 16'h0000);
    push_wr(8'h06, 16'hDFC0);
    reset = 1'b0;
    wait_init(300);
    check("rrst_init_done", 32'(init_done), 32'd1);
    @(negedge clk48);
    check("rrst_no_valid", 32'(nvalid - v0), 32'd0);
    check("rrst_port_in", 32'(port_in), 32'h0000);
    check("rrst_bus_left", 32'(exp_q.size()), 32'd0);

    // Illegal pair 0: acked with no bus traffic
    e0 = nerr;
    wr_req = 1'b1;
    wr_pair = 2'd0;
    wr_data = 16'hBEEF;
    wait_ack(20);
    check("pair0_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    repeat (40) @(negedge clk48);
    check("pair0_m_ena", 32'(m_ena), 32'd0);
    check("pair0_err_cnt", 32'(nerr - e0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/i2c_expander_sched.md
Name: i2c_expander_sched

Overview:
- Sequences the byte-level i2c_master for one 16-bit I2C port expander (PCA9555-style register pairs 0/1 input, 2/3 output, 4/5 inversion, 6/7 DDR).
- After reset it initialises the inversion and DDR registers.
- It then periodically polls the input pair and arbitrates host write requests onto the shared master.
- It sits between the top-level control logic (power rails, buttons) and the i2c_master instance.

Parameters:
- DEV_ADDR, 7'h24, 7-bit device address.
- DDR_INIT, 16'hDFC0, value for regs 6 (low byte) and 7 (high byte).
- INV_INIT, 16'h0000, value for regs 4 and 5.
- POLL_CYCLES, 6000000, clk48 cycles between input polls (0.125 s).
- TIMEOUT_CYCLES, 1000000, maximum cycles a transaction may take before it is aborted.

Ports:
- clk48 in 1: system clock.
- reset in 1: synchronous, active-high reset.
- wr_req in 1: host requests a register-pair write; held until wr_ack.
- wr_pair in 2: pair select (1=output, 2=inversion, 3=DDR; 0 is illegal and is acked without a bus transaction).
- wr_data in 16: [7:0] goes to the even register, [15:8] to the odd register.
- wr_ack out 1: 1-cycle pulse when the write completes or aborts.
- port_in out 16: last polled input value ({reg1,reg0}).
- port_in_valid out 1: 1-cycle pulse on each successful poll.
- init_done out 1: high once initialisation has succeeded.
- err out 1: 1-cycle pulse on ack_error or timeout.
- m_reset_n out 1: drives the i2c_master reset_n.
- m_ena out 1: master command enable.
- m_addr out 7: master address.
- m_rw out 1: master read/write select (1 = read).
- m_wdata out 8: master write data.
- m_busy in 1: master busy.
- m_rdata in 8: master read data.
- m_ack_error in 1: master acknowledge error.

Behaviour:
- Reset values:
  - m_ena=0, m_rw=0, m_wdata=0, m_addr=DEV_ADDR, m_reset_n=0.
  - wr_ack=0, port_in=16'h0000, port_in_valid=0, init_done=0, err=0.
  - Poll timer=0; state=RST.
- Reset mid-transaction abandons the transaction immediately. The master is held in reset (m_reset_n=0) for 1 cycle, then m_reset_n=1 permanently.
- busy_last is registered every cycle:
  - rise = m_busy & ~busy_last.
  - fall = ~m_busy & busy_last.
- Transaction engine, shared by all operations:
  - Step 0: assert m_ena=1, m_rw=0, m_wdata=pointer.
  - Each rise advances a byte index b.
  - Write transaction (3 bytes):
    - rise b0: m_wdata=data low.
    - rise b1: m_wdata=data high.
    - rise b2: m_ena=0.
  - Read transaction:
    - rise b0: m_rw=1 (repeated start).
    - rise b1: hold.
    - rise b2: m_ena=0.
    - Read data is captured on falls: fall #2 into port_in[7:0], fall #3 into port_in[15:8].
  - The transaction ends on the first fall while m_ena=0. Outputs update the cycle after that fall.
  - m_ack_error sampled high at any fall marks the transaction failed.
  - A timeout counter starts at step 0. If it reaches TIMEOUT_CYCLES, the transaction is failed: m_ena=0 and m_reset_n is pulsed low for 1 cycle.
- FSM:
  - RST -> INIT_INV.
  - INIT_INV: write pointer 4 with INV_INIT. Success -> INIT_DDR; failure -> err, then IDLE with init_done=0.
  - INIT_DDR: write pointer 6 with DDR_INIT. Success -> init_done=1, then IDLE; failure -> err, then IDLE.
  - IDLE, with init_done=0: retry INIT_INV when the poll timer expires. wr_req is not serviced until init_done=1.
  - IDLE, with init_done=1, priority order:
    1. wr_req → WR: pointer {wr_pair,1'b0}; end → wr_ack pulse (even on failure, with err).
    2. Poll timer expired → RD: pointer 0; success → port_in_valid pulse; failure → err, port_in unchanged.
  - wr_req and timer expiry in the same cycle: the write runs first and the poll stays pending. A pending poll runs at the next IDLE cycle. At most one poll is pending; further expiries while pending are dropped.
  - wr_data and wr_pair are sampled when WR starts; later changes are ignored.
- Poll timer:
  - Counts 0..POLL_CYCLES-1 and wraps, raising expiry on the wrap.
  - Free-running, not reset by transactions.
- No outputs other than m_* change mid-transaction.

Test Plan:
- Reset, master model ACKs all bytes → bus sees writes [4,00,00] then [6,C0,DF]; init_done=1 after the second end; no err.
- Input poll, model returns 8'h5A then 8'hA5 → port_in=16'hA55A, port_in_valid one cycle; the bus shows pointer 0, repeated start, 2 reads.
- wr_req with pair=1, data=16'h0020, asserted in the same cycle as poll expiry → [2,20,00] written first with a wr_ack pulse; then the poll runs; exactly one port_in_valid.
- Model NAKs the device address during INIT_DDR → err pulse, init_done=0; init retried at the next expiry; on success, init_done=1.
- Model holds m_busy low (no rise) for TIMEOUT_CYCLES during WR → err and wr_ack pulse together, m_reset_n low for 1 cycle, FSM returns to IDLE.
- reset asserted midway through a read → m_ena=0 the next cycle; no port_in_valid; the init sequence restarts from INIT_INV.
